// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: parametrised valid/ready pipeline stage buffer, 1..4 entry circular queue
// with stage-local completion (ready_go), synchronous flush and occupancy output.
module pipe_stage_buf #(
  parameter int DATA_W     = 128,
  parameter int DEPTH      = 1,
  parameter bit PASS_READY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              ready_go,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              stage_valid,
  output logic [2:0]        count
);
  localparam logic [1:0] LAST = 2'(DEPTH - 1);
  localparam logic [2:0] FULL = 3'(DEPTH);
  // Always 4 slots so 2-bit pointers index cleanly for any DEPTH; slots >= DEPTH are never written.
  logic [DATA_W-1:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign stage_valid = count != 3'd0;
  assign out_valid   = stage_valid & ready_go & ~flush;
  assign pop         = out_valid & out_ready;
  assign in_ready    = ~flush & ((count < FULL) | (PASS_READY & pop));
  assign push        = in_valid & in_ready;
  assign out_data    = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr == LAST ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr == LAST ? 2'd0 : rd_ptr + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  end
endmodule

// File: tb/tb_pipe_stage_buf.sv
// tb_pipe_stage_buf: all DEPTH x PASS_READY variants on shared stimulus, each with a queue scoreboard,
// plus directed sequences checked on selected variants.
module tb_pipe_stage_buf;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, ready_go = 1, out_ready = 0;
  logic [7:0] in_data = '0;
  logic ir [8], ov [8], sv [8];
  logic [7:0] od [8];
  logic [2:0] cnt [8];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; ready_go = 1;
    step;
    rst = 0;
  endtask
  for (genvar d = 1; d <= 4; d++) begin : g_d
    for (genvar p = 0; p < 2; p++) begin : g_p
      localparam int K = (d - 1) * 2 + p;
      pipe_stage_buf #(.DATA_W(8), .DEPTH(d), .PASS_READY(p)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[K]),
        .in_data(in_data), .ready_go(ready_go), .out_valid(ov[K]), .out_ready(out_ready),
        .out_data(od[K]), .stage_valid(sv[K]), .count(cnt[K])
      );
      logic [7:0] q [$];
      always @(negedge clk) begin
        bit ev, er;
        if (rst) q.delete();
        else begin
          ev = q.size() != 0 && ready_go && !flush;
          er = !flush && (q.size() < d || (p == 1 && ev && out_ready));
          chk($sformatf("out_valid[%0d]", K), ov[K], ev);
          chk($sformatf("in_ready[%0d]", K), ir[K], er);
          chk($sformatf("stage_valid[%0d]", K), sv[K], q.size() != 0);
          chk($sformatf("count[%0d]", K), cnt[K], q.size());
          chk($sformatf("count_max[%0d]", K), cnt[K] <= d, 1);
          if (q.size() != 0) chk($sformatf("out_data[%0d]", K), od[K], q[0]);
          if (flush) q.delete();
          else begin
            if (ev && out_ready) void'(q.pop_front());
            if (er && in_valid) q.push_back(in_data);
          end
        end
      end
    end
  end
  initial begin
    // reset and first push, DEPTH=1 PASS_READY=1 (index 1)
    do_reset;
    @(negedge clk);
    chk("rst_out_data", od[1], 0);
    chk("rst_out_valid", ov[1], 0);
    chk("rst_in_ready", ir[1], 1);
    step; in_valid = 1; in_data = 8'hA5;
    step; in_valid = 0;
    @(negedge clk);
    chk("a5_out_valid", ov[1], 1);
    chk("a5_out_data", od[1], 8'hA5);
    chk("a5_count", cnt[1], 1);
    // back-to-back through a single-entry stage
    do_reset;
    out_ready = 1; in_valid = 1; in_data = 1;
    for (int i = 2; i <= 4; i++) begin
      step; in_data = 8'(i);
      if (i == 4) in_valid = 0;
      @(negedge clk);
      chk("b2b_out_data", od[1], i - 1);
      chk("b2b_in_ready", ir[1], 1);
    end
    // backpressure, DEPTH=3 PASS_READY=0 (index 4)
    do_reset;
    in_valid = 1; in_data = 8'h10;
    step; in_data = 8'h20;
    step; in_data = 8'h30;
    step; in_valid = 0;
    @(negedge clk);
    chk("bp_count", cnt[4], 3);
    chk("bp_in_ready", ir[4], 0);
    chk("bp_hold", od[4], 8'h10);
    step; out_ready = 1;
    @(negedge clk); chk("bp_pop0", od[4], 8'h10);
    step; @(negedge clk); chk("bp_pop1", od[4], 8'h20); chk("bp_ready", ir[4], 1);
    step; @(negedge clk); chk("bp_pop2", od[4], 8'h30);
    step; @(negedge clk); chk("bp_empty", cnt[4], 0);
    in_valid = 1; in_data = 8'h40;
    step; in_valid = 0;
    @(negedge clk); chk("bp_wrap", od[4], 8'h40);
    // ready_go stall, DEPTH=2 PASS_READY=0 (index 2)
    do_reset;
    ready_go = 0; out_ready = 1; in_valid = 1; in_data = 8'h55;
    step; in_data = 8'h66;
    @(negedge clk); chk("rg_ov", ov[2], 0); chk("rg_sv", sv[2], 1);
    step; in_data = 8'h67;
    @(negedge clk); chk("rg_count", cnt[2], 2); chk("rg_refuse", ir[2], 0);
    step; in_valid = 0;
    step; @(negedge clk); chk("rg_hold", ov[2], 0);
    step; ready_go = 1;
    @(negedge clk); chk("rg_first", od[2], 8'h55); chk("rg_ov1", ov[2], 1);
    step; @(negedge clk); chk("rg_second", od[2], 8'h66);
    step; @(negedge clk); chk("rg_drained", cnt[2], 0);
    // flush, DEPTH=2 PASS_READY=1 (index 3)
    do_reset;
    in_valid = 1; in_data = 8'h01;
    step; in_data = 8'h02;
    step; in_valid = 0;
    @(negedge clk); chk("fl_count", cnt[3], 2);
    step; flush = 1; in_valid = 1; in_data = 8'h99; out_ready = 1;
    @(negedge clk); chk("fl_in_ready", ir[3], 0); chk("fl_out_valid", ov[3], 0);
    step; flush = 0; in_valid = 0;
    @(negedge clk); chk("fl_cleared", cnt[3], 0); chk("fl_sv", sv[3], 0);
    step; in_valid = 1; in_data = 8'h77;
    step; in_valid = 0;
    @(negedge clk); chk("fl_after", od[3], 8'h77); chk("fl_cnt1", cnt[3], 1);
    // random stress on every variant
    do_reset;
    for (int i = 0; i < 3000; i++) begin
      step;
      in_valid  = 1'($urandom_range(1));
      in_data   = 8'($urandom);
      out_ready = $urandom_range(3) != 0;
      ready_go  = $urandom_range(4) != 0;
      flush     = $urandom_range(99) == 0;
      rst       = $urandom_range(99) == 0;
    end
    step; rst = 0; flush = 0; in_valid = 0;
    step;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Generic parametrised pipeline-stage buffer with a valid/ready handshake, for use between any two CPU pipeline stages (IF/ID/EX/MEM/WB).
It generalises the single-entry stage register with a configurable payload width and depth (1..4 entries, circular buffer).
It adds a selectable ready path (combinational pass-through or registered), a synchronous flush for branch and exception kills, and an occupancy output.
A single instance replaces the per-stage hand-written registers; payload fields are concatenated by the instantiating stage.

Parameters:
DATA_W, 128, payload width in bits (1..512)
DEPTH, 1, number of entries (1..4; 3 is legal, so pointers do not rely on power-of-2 wrap)
PASS_READY, 1, 1 = in_ready also asserted when full and the head is popping this cycle (combinational out_ready->in_ready path); 0 = in_ready depends only on registered state

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
flush  input  1  kill all held entries this cycle
in_valid  input  1  upstream offers in_data
in_ready  output  1  buffer can accept this cycle
in_data  input  DATA_W  upstream payload
ready_go  input  1  head entry finished in this stage (stage-local completion, e.g. multicycle op done)
out_valid  output  1  head entry offered downstream
out_ready  input  1  downstream accepts
out_data  output  DATA_W  head entry payload
stage_valid  output  1  at least one entry held, independent of ready_go (for hazard and forwarding logic)
count  output  3  current occupancy, 0..DEPTH

Behaviour:
- Storage: DEPTH x DATA_W registers, plus wr_ptr, rd_ptr (0..DEPTH-1) and count.
- Reset: count=0, wr_ptr=0, rd_ptr=0, all entries=0. Therefore out_valid=0, stage_valid=0, out_data=0, and in_ready=1 after reset.
- stage_valid = (count!=0).
- out_valid = (count!=0) & ready_go & ~flush.
- out_data = entry[rd_ptr], combinational from registers. When the buffer is empty, out_data holds whatever entry[rd_ptr] last contained.
- in_ready:
  - PASS_READY=1: ~flush & ((count<DEPTH) | (out_ready & out_valid)).
  - PASS_READY=0: ~flush & (count<DEPTH).
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Latency: a push in cycle N makes the entry visible on out_data and stage_valid in cycle N+1. There is no same-cycle bypass.
- On push, entry[wr_ptr] <= in_data. On pop, rd_ptr advances. Both pointers wrap: DEPTH-1 -> 0.
- Occupancy update:
  - push & ~pop: count+1.
  - pop & ~push: count-1.
  - both: count unchanged, both pointers advance.
- Full with pop and push in the same cycle (PASS_READY=1): both occur and FIFO order is kept. The new entry writes the slot freed by the pop; with DEPTH=1 this gives exactly the classic stage-register behaviour.
- Empty with push only: count 0->1, out_valid rises next cycle (if ready_go).
- ready_go=0: the head is held, out_valid=0, and no pop occurs. Pushes still accepted while count<DEPTH.
- out_valid=1 & out_ready=0: out_data and the head stay stable until pop (AXI-style hold).
- in_data is sampled only on push. Entries not being written hold their value.
- flush:
  - In the flush cycle, in_ready=0 and out_valid=0, so no push or pop.
  - Next cycle: count=0, wr_ptr=rd_ptr=0. Entry contents are not cleared.
- Precedence: rst > flush > push/pop.
- rst asserted mid-transfer: state returns to the reset values next cycle regardless of the handshakes.
- Overflow and underflow are impossible by construction. The bench asserts count<=DEPTH every cycle.

Test Plan:
- Reset, DEPTH=1: after rst, out_valid=0, out_data=0, in_ready=1. Push 0xA5 -> next cycle out_valid=1, out_data=0xA5, count=1.
- Back-to-back, DEPTH=1, PASS_READY=1, out_ready=1, ready_go=1: push 1,2,3 on consecutive cycles -> out_data 1,2,3 on consecutive cycles, in_ready held 1, throughput 1 per cycle.
- Backpressure, DEPTH=3, PASS_READY=0: out_ready=0, push 0x10,0x20,0x30 -> count=3, in_ready=0, out_data=0x10 stable. Then raise out_ready -> outputs 0x10,0x20,0x30 in order, pointers wrap 2->0, in_ready=1 after the first pop.
- ready_go stall, DEPTH=2: head 0x55 held with ready_go=0 for 4 cycles -> out_valid=0, stage_valid=1. A second push of 0x66 is accepted (count=2) and a third is refused. ready_go=1 -> 0x55 then 0x66.
- Flush: with count=2, assert flush together with in_valid=1 and out_ready=1 -> in_ready=0 and out_valid=0 that cycle, no pop. Next cycle count=0, stage_valid=0. A following push 0x77 appears as out_data=0x77 one cycle later.
- Random stress, all DEPTH×PASS_READY combinations: random in_valid, out_ready, ready_go, with 1% flush and rst -> the scoreboard matches FIFO order and count<=DEPTH always.
